// File: rtl/ex_pkg.sv
// Shared definitions for the execute-stage multiply/divide sequencer:
// operation encodings, FSM state type and iteration-counter sizing.
package ex_pkg;

  localparam logic [1:0] MULDIV_MULTU = 2'b00;
  localparam logic [1:0] MULDIV_MULT  = 2'b01;
  localparam logic [1:0] MULDIV_DIVU  = 2'b10;
  localparam logic [1:0] MULDIV_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_t;

  // Iteration counter width for a given operand width.
  function automatic int muldiv_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_step.sv
// One radix-2 iteration of the multiply/divide datapath.
// Accumulator layout is {upper (WIDTH+1 bits), lower (WIDTH bits)}.
//   multiply: lower holds the unconsumed multiplier bits; add the multiplicand
//             into the upper half when the multiplier LSB is set, then shift right.
//   divide:   upper is the partial remainder, lower the dividend/quotient;
//             shift left, trial-subtract the divisor, keep it if non-negative.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH:0]     acc_in,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH:0]     acc_out
);

  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH:0] mul_pre;
  logic [2*WIDTH:0] div_sh;
  logic [WIDTH+1:0] div_diff;

  // Single-iteration add/shift or trial-subtract/shift.
  always_comb begin
    mul_sum  = acc_in[0] ? ({1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, operand})
                         : {1'b0, acc_in[2*WIDTH-1:WIDTH]};
    mul_pre  = {mul_sum, acc_in[WIDTH-1:0]};
    div_sh   = {acc_in[2*WIDTH-1:0], 1'b0};
    div_diff = {1'b0, div_sh[2*WIDTH:WIDTH]} - {2'b00, operand};
    if (!is_div) begin
      acc_out = {1'b0, mul_pre[2*WIDTH:1]};
    end else if (!div_diff[WIDTH+1]) begin
      acc_out = {div_diff[WIDTH:0], div_sh[WIDTH-1:1], 1'b1};
    end else begin
      acc_out = div_sh;
    end
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with architectural HI/LO.
// Optional build macro: MULDIV_EARLY_OUT_EN (multiply terminates once the
// remaining multiplier bits are zero).
//
//   state | meaning
//   IDLE  | waiting for start; HI/LO hold last result
//   RUN   | one add/shift or subtract/shift iteration per cycle
//   FIX   | sign correction, HI/LO write, done pulse
module ex_muldiv_ctrl
  import ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CNT_W = muldiv_cnt_w(WIDTH);
  localparam int AW    = 2 * WIDTH + 1;

  muldiv_state_t    state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    acc, acc_step, acc_run;
  logic [WIDTH-1:0] opa, opb;
  logic             is_div, neg_q, neg_r, dbz;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             last_iter, run_to_fix, idle_to_fix;
  logic             accept;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem, hi_nxt, lo_nxt;

  assign busy   = (state != ST_IDLE);
  assign stall  = busy | start;
  assign accept = (state == ST_IDLE) && start && !flush;

  // Operand magnitudes and result signs for the signed variants (op[0]=1).
  always_comb begin
    a_neg = op[0] & src_a[WIDTH-1];
    b_neg = op[0] & src_b[WIDTH-1];
    a_mag = a_neg ? -src_a : src_a;
    b_mag = b_neg ? -src_b : src_b;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc_in  (acc),
    .operand (is_div ? opb : opa),
    .acc_out (acc_step)
  );

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

`ifdef MULDIV_EARLY_OUT_EN
  logic [WIDTH-1:0] mplier_left;
  logic             early_out;

  // Multiply finishes as soon as no multiplier bits remain; the accumulator
  // is realigned by the shifts that were skipped.
  always_comb begin
    mplier_left = opb >> (cnt + CNT_W'(1));
    early_out   = !is_div && (mplier_left == '0);
    run_to_fix  = last_iter || early_out;
    acc_run     = early_out ? (acc_step >> (CNT_W'(WIDTH - 1) - cnt)) : acc_step;
    idle_to_fix = !op[1] && (src_b == '0);
  end
`else
  // Fixed-latency build: always WIDTH iterations.
  always_comb begin
    run_to_fix  = last_iter;
    acc_run     = acc_step;
    idle_to_fix = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; flush overrides everything, including a same-cycle start.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state_nxt = idle_to_fix ? ST_FIX : ST_RUN;
        ST_RUN:  if (run_to_fix) state_nxt = ST_FIX;
        ST_FIX:  state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Operand capture at issue and iteration update while running.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      acc    <= '0;
      opa    <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dbz    <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      acc    <= {{(WIDTH + 1){1'b0}}, (op[1] ? a_mag : b_mag)};
      opa    <= a_mag;
      opb    <= b_mag;
      is_div <= op[1];
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      dbz    <= op[1] && (src_b == '0);
    end else if (state == ST_RUN && !flush) begin
      cnt <= cnt + CNT_W'(1);
      acc <= acc_run;
    end
  end

  // Sign fix-up of the raw magnitude result; divide-by-zero forces LO to all ones
  // while HI naturally recovers the original dividend.
  always_comb begin
    prod = neg_q ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (dbz) quo = '1;
    if (is_div) begin
      hi_nxt = rem;
      lo_nxt = quo;
    end else begin
      hi_nxt = prod[2*WIDTH-1:WIDTH];
      lo_nxt = prod[WIDTH-1:0];
    end
  end

  // Architectural HI/LO, completion pulse and divide-by-zero flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= (state == ST_FIX) && !flush;
      if (state == ST_FIX && !flush) begin
        hi          <= hi_nxt;
        lo          <= lo_nxt;
        div_by_zero <= is_div && dbz;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed self-checking bench for ex_muldiv_ctrl (WIDTH=32).
module tb_ex_muldiv_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        busy, stall, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;

  ex_muldiv_ctrl #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .flush       (flush),
    .busy        (busy),
    .stall       (stall),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected start-to-done latency in cycles.
  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
    int lat;
    lat = 34;
`ifdef MULDIV_EARLY_OUT_EN
    if (!o[1]) begin
      logic [31:0] bm;
      int msb;
      bm  = (o[0] && b[31]) ? -b : b;
      msb = -1;
      for (int i = 0; i < 32; i++) if (bm[i]) msb = i;
      lat = (msb < 0) ? 2 : 3 + msb;
    end
`endif
    return lat;
  endfunction

  // Issue one op, optionally poke a start while busy at cycle 'poke', and
  // check latency, stall behaviour and results.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edbz, input int poke);
    int cyc;
    bit hold_bad;
    @(negedge clock);
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    check({tag, "_stall_issue"}, 32'(stall), 32'd1);
    cyc = 0;
    hold_bad = 1'b0;
    while (cyc < 60) begin
      @(negedge clock);
      cyc++;
      start = (cyc == poke);
      if (cyc == poke) begin
        op = 2'b10; src_a = 32'd100; src_b = 32'd3;
      end
      #1;
      if (done) break;
      if (!stall || !busy) hold_bad = 1'b1;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat(o, b)));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_stall_hold"}, 32'(hold_bad), 32'd0);
    check({tag, "_stall_drop"}, 32'(stall), 32'd0);
    check({tag, "_hi"}, hi, ehi);
    check({tag, "_lo"}, lo, elo);
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
    @(negedge clock);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, 1'b0, -1);
    run_op("mult_neg", 2'b01, -32'sd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, -1);
    run_op("div_neg", 2'b11, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, -1);
    run_op("divu_zero", 2'b10, 32'd10, 32'd0, 32'h0000_000A, 32'hFFFF_FFFF, 1'b1, -1);
    run_op("multu_clr", 2'b00, 32'd2, 32'd3, 32'h0, 32'h6, 1'b0, -1);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, -1);
    run_op("div_negb", 2'b11, 32'd7, -32'sd2, 32'h1, 32'hFFFF_FFFD, 1'b0, -1);
    run_op("multu_7x1", 2'b00, 32'd7, 32'd1, 32'h0, 32'h7, 1'b0, -1);
    run_op("multu_7x0", 2'b00, 32'd7, 32'd0, 32'h0, 32'h0, 1'b0, -1);
    run_op("poke_busy", 2'b00, 32'd5, 32'd7, 32'h0, 32'd35, 1'b0, 2);
    run_op("setup", 2'b10, 32'h451, 32'h20, 32'h11, 32'h22, 1'b0, -1);

    // Flush at cycle 10 of a DIV.
    @(negedge clock);
    start = 1'b1; op = 2'b11; src_a = -32'sd100; src_b = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (c == 10) flush = 1'b1;
    end
    #1;
    check("flush_busy_before", 32'(busy), 32'd1);
    @(negedge clock);
    flush = 1'b0;
    #1;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    check("flush_hi", hi, 32'h11);
    check("flush_lo", lo, 32'h22);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      #1;
      if (done || busy) seen = 1'b1;
    end
    check("flush_no_done", 32'(seen), 32'd0);

    // start and flush in the same cycle: not accepted.
    @(negedge clock);
    start = 1'b1; flush = 1'b1; op = 2'b00; src_a = 32'd5; src_b = 32'd5;
    @(negedge clock);
    start = 1'b0; flush = 1'b0;
    #1;
    check("sflush_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      #1;
      if (done || busy) seen = 1'b1;
    end
    check("sflush_no_done", 32'(seen), 32'd0);
    check("sflush_hi", hi, 32'h11);
    check("sflush_lo", lo, 32'h22);

    // Asynchronous reset mid-RUN.
    @(negedge clock);
    start = 1'b1; op = 2'b00; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      start = 1'b0;
    end
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    check("arst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run_op("after_rst", 2'b00, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_ctrl.md
# ex_muldiv_ctrl

Multi-cycle multiply/divide sequencer beside the execute stage. It accepts MIPS MULT/MULTU/DIV/DIVU operations from ID/EX, runs a radix-2 iterative shift-add or restoring-divide datapath one bit per cycle, and raises `stall` so the pipeline holds younger instructions. Results land in architectural HI/LO registers that later MFHI/MFLO read through `hi`/`lo`.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `start` in 1: issue request, qualified by `busy`=0.
- `op` in 2: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `src_a` in WIDTH: multiplicand or dividend (rs).
- `src_b` in WIDTH: multiplier or divisor (rt).
- `flush` in 1: abort the in-flight operation (branch/exception squash).
- `busy` out 1: operation in flight.
- `stall` out 1: combinational `busy | start`; holds IF/ID and ID/EX.
- `done` out 1: one-cycle pulse on the cycle HI/LO become valid.
- `hi` out WIDTH: product upper half, or remainder.
- `lo` out WIDTH: product lower half, or quotient.
- `div_by_zero` out 1: last completed DIV/DIVU had `src_b`=0.

## Operation
- FSM states: IDLE, RUN, FIX.
- **IDLE:** when `start`=1, latch op and operand magnitudes (two's-complement absolute value for signed ops), record result sign and remainder sign, clear accumulator, set count=0, go to RUN. `start` while `busy`=1 is ignored.
- **RUN:** one iteration per cycle. Multiply: add multiplicand to the upper accumulator if multiplier LSB=1, then shift right. Divide: shift the remainder left, trial-subtract the divisor, set the quotient bit if the result is non-negative. After `WIDTH` iterations, go to FIX.
- **FIX:** negate as needed. MULT: 2·WIDTH product. DIV: quotient takes sign a⊕b, remainder takes the sign of the dividend. Write `hi`/`lo`, pulse `done`, return to IDLE.
- **Divide by zero:** full latency. `lo` = all ones, `hi` = `src_a` unchanged, `div_by_zero`=1.
- `div_by_zero` holds until the next completed operation, which overwrites it.
- Signed overflow case −2^(W−1)/−1: `lo` = 0x80000000, `hi` = 0, no flag.
- **flush:** has priority over every other event, including `start` in the same cycle. Next state is IDLE, `busy`=0, no `done`, and `hi`/`lo`/`div_by_zero` keep their pre-op values.
- **Reset values:** state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_by_zero`=0. Reset mid-operation discards it.

## Timing
- Edge 0 samples `start`. `busy`=1 from edge 0 through edge WIDTH+1.
- RUN occupies edges 1..WIDTH. Edge WIDTH+1 is FIX, which writes HI/LO and asserts `done`.
- Total latency is WIDTH+2 cycles from `start` to `done` (34 at WIDTH=32).
- `stall` is high in the `start` cycle and every busy cycle. It drops in the `done` cycle, so a dependent MFHI/MFLO issues that cycle and reads the new values.
- A new `start` is accepted in the `done` cycle. Back-to-back issue period is WIDTH+2.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined: in RUN, multiply ops go to FIX as soon as the remaining multiplier bits are all zero, with the accumulator shifted the remaining positions in that step. Latency becomes 2 + index of the highest set bit + 1, and 2 when `src_b`=0. Results are identical. Divide is unaffected.
- Undefined: fixed WIDTH+2 latency for all ops.

## Structure
- Shared package `ex_pkg` holds:
  - the `op` encodings (MULDIV_MULTU, MULDIV_MULT, MULDIV_DIVU, MULDIV_DIV);
  - the FSM state enum;
  - the iteration-counter width `$clog2(WIDTH+1)`.
- One sub-module, `muldiv_step`: combinational single-iteration datapath (add/shift or trial-subtract/shift). The FSM, counter and HI/LO registers live in the top.

## Test plan
- MULTU 0xFFFFFFFF × 0x00000002 → `done` at cycle 34; `hi`=0x00000001, `lo`=0xFFFFFFFE; `stall` high for cycles 0–33.
- MULT −3 × 5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. DIV −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU 10 / 0 → `lo`=0xFFFFFFFF, `hi`=0x0000000A, `div_by_zero`=1. A following MULTU 2×3 clears the flag and gives `lo`=6.
- `flush` at cycle 10 of a DIV, with prior `hi`/`lo`=0x11/0x22 → `busy`=0 at cycle 11, no `done`, `hi`/`lo` still 0x11/0x22. `start`+`flush` in the same cycle → operation not accepted.
- `reset_n` low mid-RUN → `busy`, `done`, `hi`, `lo` all 0 immediately. `start` while busy is ignored, with no change to the in-flight result.
- With `MULDIV_EARLY_OUT_EN`: MULTU 7 × 1 → `done` at cycle 3 with `lo`=7. MULTU 7 × 0 → `done` at cycle 2 with `lo`=0.
